game_ctrl: RTL and testbench

Turn sequencer for the connect-four board datapath (state_update). It turns raw push-button levels into single-cycle put/right/left command pulses and owns the turn bit. It waits for the win checker to settle after each drop, then detects invalid drops, wins, draws and per-turn timeouts. It sits between the board I/O and state_update; win_a/win_b come from the win detector and invalid_move comes back from state_update.

---
 rtl/game_pkg.sv | 21 ++
 rtl/game_ctrl_btn_edge.sv | 24 ++
 rtl/game_ctrl.sv | 141 ++++++++++++++
 tb/tb_game_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the connect-four turn sequencer and board datapath.
package game_pkg;
    typedef enum logic [1:0] {
        WAIT_INPUT = 2'd0,
        CHECK      = 2'd1,
        GAME_OVER  = 2'd2
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_A    = 2'b01;
    localparam logic [1:0] WIN_B    = 2'b10;

    // Cell colours as stored by state_update.
    localparam logic [1:0] EMPTY     = 2'b00;
    localparam logic [1:0] A         = 2'b01;
    localparam logic [1:0] B         = 2'b10;
    localparam logic [1:0] HIGHLIGHT = 2'b11;

    localparam int ROWS = 6;
    localparam int COLS = 7;
endpackage

// File: rtl/game_ctrl_btn_edge.sv
// Two-flop synchronizer plus rising-edge detector for one raw push button.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);
    logic sync1, sync2, prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Combinational edge; the command output register in game_ctrl adds the third cycle.
    assign pulse = sync2 & ~prev;
endmodule

// File: rtl/game_ctrl.sv
// Turn sequencer: button edges to command pulses, turn ownership, and
// win/draw/invalid/timeout resolution after each drop.
module game_ctrl
    import game_pkg::*;
#(
    parameter int CHECK_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int MAX_MOVES      = 42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_put,
    input  logic       btn_right,
    input  logic       btn_left,
    input  logic       win_a,
    input  logic       win_b,
    input  logic       invalid_move,
    output logic       turn,
    output logic       put,
    output logic       right,
    output logic       left,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [5:0] move_cnt,
    output logic       timeout_p,
    output logic       retry_p
);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic put_e, right_e, left_e;

    btn_edge u_put   (.clk(clk), .rst(rst), .btn(btn_put),   .pulse(put_e));
    btn_edge u_right (.clk(clk), .rst(rst), .btn(btn_right), .pulse(right_e));
    btn_edge u_left  (.clk(clk), .rst(rst), .btn(btn_left),  .pulse(left_e));

    state_t        state, state_d;
    logic          turn_d, put_d, right_d, left_d, timeout_d, retry_d, inv_prev, inv_prev_d;
    logic [1:0]    winner_d;
    logic [5:0]    mc_d;
    logic [3:0]    chk_cnt, chk_d;
    logic [TW-1:0] to_cnt, to_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= WAIT_INPUT;
            turn      <= 1'b0;
            put       <= 1'b0;
            right     <= 1'b0;
            left      <= 1'b0;
            timeout_p <= 1'b0;
            retry_p   <= 1'b0;
            winner    <= WIN_NONE;
            move_cnt  <= '0;
            chk_cnt   <= '0;
            to_cnt    <= '0;
            inv_prev  <= 1'b0;
        end else begin
            state     <= state_d;
            turn      <= turn_d;
            put       <= put_d;
            right     <= right_d;
            left      <= left_d;
            timeout_p <= timeout_d;
            retry_p   <= retry_d;
            winner    <= winner_d;
            move_cnt  <= mc_d;
            chk_cnt   <= chk_d;
            to_cnt    <= to_d;
            inv_prev  <= inv_prev_d;
        end
    end

    always_comb begin
        state_d    = state;
        turn_d     = turn;
        put_d      = 1'b0;
        right_d    = 1'b0;
        left_d     = 1'b0;
        timeout_d  = 1'b0;
        retry_d    = 1'b0;
        winner_d   = winner;
        mc_d       = move_cnt;
        chk_d      = chk_cnt;
        to_d       = to_cnt;
        inv_prev_d = inv_prev;
        case (state)
            WAIT_INPUT: begin
                to_d = (TIMEOUT_CYCLES > 0) ? to_cnt + TW'(1) : '0;
                if (put_e) begin
                    put_d      = 1'b1;
                    inv_prev_d = invalid_move;
                    chk_d      = '0;
                    to_d       = '0;
                    state_d    = CHECK;
                end else if (right_e) begin
                    right_d = 1'b1;
                    to_d    = '0;
                end else if (left_e) begin
                    left_d = 1'b1;
                    to_d   = '0;
                end else if (TIMEOUT_CYCLES > 0 && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    turn_d    = ~turn;
                    timeout_d = 1'b1;
                    to_d      = '0;
                end
            end
            CHECK: begin
                if (chk_cnt == 4'(CHECK_CYCLES - 1)) begin
                    to_d = '0;
                    if (win_a) begin
                        state_d  = GAME_OVER;
                        winner_d = WIN_A;
                    end else if (win_b) begin
                        state_d  = GAME_OVER;
                        winner_d = WIN_B;
                    end else if (invalid_move && !inv_prev) begin
                        // invalid_move is sticky: only its first rise marks a rejected drop
                        retry_d = 1'b1;
                        state_d = WAIT_INPUT;
                    end else begin
                        if (move_cnt < 6'(MAX_MOVES))
                            mc_d = move_cnt + 6'd1;
                        if (mc_d == 6'(MAX_MOVES)) begin
                            state_d  = GAME_OVER;
                            winner_d = WIN_NONE;
                        end else begin
                            turn_d  = ~turn;
                            state_d = WAIT_INPUT;
                        end
                    end
                end else begin
                    chk_d = chk_cnt + 4'd1;
                end
            end
            GAME_OVER: ;
            default: state_d = WAIT_INPUT;
        endcase
    end

    assign game_over = (state == GAME_OVER);
endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: stimulus queues expected observations, monitors pop and compare.
module tb_game_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0, rst2 = 1'b0;
    logic btn_put = 1'b0, btn_right = 1'b0, btn_left = 1'b0;
    logic win_a = 1'b0, win_b = 1'b0, invalid_move = 1'b0;
    logic zero = 1'b0;

    logic turn, put, right, left, game_over, timeout_p, retry_p;
    logic [1:0] winner;
    logic [5:0] move_cnt;
    logic t_turn, t_put, t_right, t_left, t_game_over, t_timeout_p, t_retry_p;
    logic [1:0] t_winner;
    logic [5:0] t_move_cnt;

    game_ctrl #(.CHECK_CYCLES(2), .TIMEOUT_CYCLES(0), .MAX_MOVES(42)) dut (
        .clk(clk), .rst(rst), .btn_put(btn_put), .btn_right(btn_right), .btn_left(btn_left),
        .win_a(win_a), .win_b(win_b), .invalid_move(invalid_move),
        .turn(turn), .put(put), .right(right), .left(left), .game_over(game_over),
        .winner(winner), .move_cnt(move_cnt), .timeout_p(timeout_p), .retry_p(retry_p));

    game_ctrl #(.CHECK_CYCLES(2), .TIMEOUT_CYCLES(20), .MAX_MOVES(42)) dut_to (
        .clk(clk), .rst(rst2), .btn_put(zero), .btn_right(zero), .btn_left(zero),
        .win_a(zero), .win_b(zero), .invalid_move(zero),
        .turn(t_turn), .put(t_put), .right(t_right), .left(t_left), .game_over(t_game_over),
        .winner(t_winner), .move_cnt(t_move_cnt), .timeout_p(t_timeout_p), .retry_p(t_retry_p));

    // pulses = {put, right, left, timeout_p, retry_p}
    typedef struct packed {
        logic [4:0] pulses;
        logic       go;
        logic       turn;
        logic [1:0] winner;
        logic [5:0] mc;
    } obs_t;
    typedef struct {
        obs_t o;
        int   cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   errors = 0, checks = 0, cyc = 0;
    bit   mon1_en = 0, mon2_en = 0;
    obs_t prev1, prev2;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t mk(input logic [4:0] p, input logic g, input logic t,
                                input logic [1:0] w, input int m);
        obs_t o;
        o.pulses = p; o.go = g; o.turn = t; o.winner = w; o.mc = m[5:0];
        return o;
    endfunction

    task automatic push1(input obs_t o, input int c);
        exp_t e; e.o = o; e.cyc = c; q1.push_back(e);
    endtask

    task automatic push2(input obs_t o, input int c);
        exp_t e; e.o = o; e.cyc = c; q2.push_back(e);
    endtask

    task automatic chk_ev(input string nm, input obs_t got, input int gc, input bit have, input exp_t e);
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL %s unexpected event: got %h at cyc %0d, required no event", nm, got, gc);
        end else if (got !== e.o || gc != e.cyc) begin
            errors++;
            $display("FAIL %s event: got %h at cyc %0d, required %h at cyc %0d", nm, got, gc, e.o, e.cyc);
        end
    endtask

    task automatic chk_eq(input string nm, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask

    function automatic obs_t cur1();
        return mk({put, right, left, timeout_p, retry_p}, game_over, turn, winner, 32'(move_cnt));
    endfunction

    function automatic obs_t cur2();
        return mk({t_put, t_right, t_left, t_timeout_p, t_retry_p}, t_game_over, t_turn, t_winner,
                  32'(t_move_cnt));
    endfunction

    always @(negedge clk) begin : mon1
        obs_t c;
        exp_t e;
        c = cur1();
        if (!mon1_en) prev1 = '0;
        else begin
            if (c.pulses != 5'd0 || c[9:0] != prev1[9:0]) begin
                if (q1.size() > 0) begin e = q1.pop_front(); chk_ev("main", c, cyc, 1'b1, e); end
                else chk_ev("main", c, cyc, 1'b0, e);
            end
            prev1 = c;
        end
    end

    always @(negedge clk) begin : mon2
        obs_t c;
        exp_t e;
        c = cur2();
        if (!mon2_en) prev2 = '0;
        else begin
            if (c.pulses != 5'd0 || c[9:0] != prev2[9:0]) begin
                if (q2.size() > 0) begin e = q2.pop_front(); chk_ev("timeout", c, cyc, 1'b1, e); end
                else chk_ev("timeout", c, cyc, 1'b0, e);
            end
            prev2 = c;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon1_en = 0;
        btn_put = 0; btn_right = 0; btn_left = 0;
        win_a = 0; win_b = 0; invalid_move = 0;
        rst = 0;
        #1;
        chk_eq("reset_state", cur1(), '0);
        tick(1);
        rst = 1;
        mon1_en = 1;
    endtask

    // Successful drop: put pulse 3 cycles after press, commit 2 cycles later.
    task automatic drop(input logic tn, input int mcv, input bit last, input bit with_left);
        int c0;
        c0 = cyc;
        btn_put = 1; btn_left = with_left;
        push1(mk(5'b10000, 1'b0, tn, 2'b00, mcv), c0 + 3);
        if (last) push1(mk(5'b00000, 1'b1, tn, 2'b00, mcv + 1), c0 + 5);
        else      push1(mk(5'b00000, 1'b0, ~tn, 2'b00, mcv + 1), c0 + 5);
        tick(4);
        btn_put = 0; btn_left = 0;
        tick(4);
    endtask

    initial begin : wdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin : stim
        int c0;
        tick(2);
        do_reset();

        // right held 10 cycles: one pulse, 3 cycles after the rise
        c0 = cyc;
        btn_right = 1;
        push1(mk(5'b01000, 1'b0, 1'b0, 2'b00, 0), c0 + 3);
        tick(10);
        btn_right = 0;
        tick(3);

        // rejected drop: invalid_move rises during CHECK
        c0 = cyc;
        btn_put = 1;
        push1(mk(5'b10000, 1'b0, 1'b0, 2'b00, 0), c0 + 3);
        push1(mk(5'b00001, 1'b0, 1'b0, 2'b00, 0), c0 + 5);
        tick(4);
        invalid_move = 1; btn_put = 0;
        tick(4);

        // invalid_move stays high: next drop counts as a move
        drop(1'b0, 0, 1'b0, 1'b0);

        // player B wins on its drop
        c0 = cyc;
        btn_put = 1;
        push1(mk(5'b10000, 1'b0, 1'b1, 2'b00, 1), c0 + 3);
        push1(mk(5'b00000, 1'b1, 1'b1, 2'b10, 1), c0 + 5);
        tick(4);
        win_b = 1; btn_put = 0;
        tick(4);

        // presses after game over produce nothing
        btn_put = 1; btn_right = 1;
        tick(5);
        btn_put = 0; btn_right = 0; btn_left = 1;
        tick(5);
        btn_left = 0;
        tick(3);
        chk_eq("hold_game_over", cur1(), mk(5'b00000, 1'b1, 1'b1, 2'b10, 1));

        do_reset();

        // fill the board; drop 5 also presses left in the same cycle
        for (int i = 0; i < 42; i++)
            drop(i[0], i, i == 41, i == 5);
        tick(2);
        chk_eq("board_full", cur1(), mk(5'b00000, 1'b1, 1'b1, 2'b00, 42));
        btn_right = 1;
        tick(5);
        btn_right = 0;
        tick(3);

        // timeout instance: forfeits at 20 and 40 cycles after reset release
        #1;
        chk_eq("timeout_reset_state", cur2(), '0);
        tick(1);
        c0 = cyc;
        push2(mk(5'b00010, 1'b0, 1'b1, 2'b00, 0), c0 + 20);
        push2(mk(5'b00010, 1'b0, 1'b0, 2'b00, 0), c0 + 40);
        rst2 = 1;
        mon2_en = 1;
        tick(45);
        mon2_en = 0;
        rst2 = 0;
        tick(2);

        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL main_pending: got %0d events outstanding, required 0", q1.size());
        end
        checks++;
        if (q2.size() != 0) begin
            errors++;
            $display("FAIL timeout_pending: got %0d events outstanding, required 0", q2.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
